vga_pattern_control: RTL

VGA_PATTERN_CONTROL -- requirements
Module: vga_pattern_control

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_box_mover.sv | 98 +++++++++
 rtl/vga_pattern_control.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA test-pattern generator:
//   - active-area dimensions (H_ACTIVE x V_ACTIVE)
//   - pattern state encoding (BARS, CHECKER, BOX)
//   - 3-bit colour codes packed as {R,G,B}
//   - helper that maps a column to its colour-bar code
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Width of one colour bar: 8 bars across the active line.
  localparam int BAR_W = H_ACTIVE / 8;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    CHECKER = 2'd1,
    BOX     = 2'd2
  } pattern_t;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  // Bar k (columns 80k..80k+79) shows code 7-k: white on the left, black on
  // the right. Written as a threshold chain to avoid a divider.
  function automatic logic [2:0] bar_colour(input logic [10:0] col);
    logic [2:0] code;
    code = 3'd7;
    if (col >= 11'(1 * BAR_W)) code = 3'd6;
    if (col >= 11'(2 * BAR_W)) code = 3'd5;
    if (col >= 11'(3 * BAR_W)) code = 3'd4;
    if (col >= 11'(4 * BAR_W)) code = 3'd3;
    if (col >= 11'(5 * BAR_W)) code = 3'd2;
    if (col >= 11'(6 * BAR_W)) code = 3'd1;
    if (col >= 11'(7 * BAR_W)) code = 3'd0;
    return code;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// -----------------------------------------------------------------------------
// vga_box_mover
// Position and bounce logic of the moving box. Once per enabled frame event
// each axis steps by BOX_STEP towards its current direction and reverses when
// it reaches either edge, clamping exactly onto the edge.
//
// Ports:
//   clk         in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   frame_event in   1-cycle pulse, one per frame
//   enable      in   allow the box to move on this frame event
//   restart     in   return box to (0,0) heading down-right
//   box_x       out  10-bit left edge of the box
//   box_y       out  10-bit top edge of the box
// -----------------------------------------------------------------------------
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_event,
  input  logic       enable,
  input  logic       restart,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [10:0] X_LIMIT = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_LIMIT = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP    = 11'(BOX_STEP);

  logic dx;
  logic dy;

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       dx_next;
  logic       dy_next;

  // One axis of the bounce: all comparisons in 11 bits so pos+STEP cannot
  // wrap, and the result is clamped to [0, limit].
  function automatic logic [10:0] bounce(input logic [9:0]  pos,
                                         input logic        dir,
                                         input logic [10:0] limit);
    logic [10:0] p;
    logic [10:0] moved;
    logic [9:0]  new_pos;
    logic        new_dir;
    p = {1'b0, pos};
    new_dir = dir;
    if (dir) begin
      moved = p + STEP;
      if (moved >= limit) begin
        new_pos = limit[9:0];
        new_dir = 1'b0;
      end else begin
        new_pos = moved[9:0];
      end
    end else begin
      moved = p - STEP;
      if (p <= STEP) begin
        new_pos = 10'd0;
        new_dir = 1'b1;
      end else begin
        new_pos = moved[9:0];
      end
    end
    return {new_dir, new_pos};
  endfunction

  always_comb begin
    {dx_next, x_next} = bounce(box_x, dx, X_LIMIT);
    {dy_next, y_next} = bounce(box_y, dy, Y_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x <= '0;
      box_y <= '0;
      dx    <= 1'b1;
      dy    <= 1'b1;
    end else if (restart) begin
      box_x <= '0;
      box_y <= '0;
      dx    <= 1'b1;
      dy    <= 1'b1;
    end else if (frame_event && enable) begin
      box_x <= x_next;
      box_y <= y_next;
      dx    <= dx_next;
      dy    <= dy_next;
    end
  end

endmodule

// File: rtl/vga_pattern_control.sv
// -----------------------------------------------------------------------------
// vga_pattern_control
// Test-pattern generator sitting behind a VGA sync generator. It cycles
// through colour bars, a 32-pixel checkerboard and a bouncing box, showing
// each pattern for FRAMES_PER_PATTERN frames. Colour and syncs are registered
// together so they leave with exactly one clock of latency.
//
// Ports:
//   CLK              in   pixel clock (25.175 MHz nominal)
//   RST_n            in   asynchronous active-low reset
//   Ready_Sig        in   active-area flag; addresses valid while high
//   Column_Addr_Sig  in   11-bit x address (0..639)
//   Row_Addr_Sig     in   11-bit y address (0..479)
//   HSYNC_In_Sig     in   active-low hsync from the sync generator
//   VSYNC_In_Sig     in   active-low vsync from the sync generator
//   HSYNC_Sig        out  hsync delayed one clock
//   VSYNC_Sig        out  vsync delayed one clock
//   Red_Sig/Green_Sig/Blue_Sig  out  pixel colour {R,G,B}
// -----------------------------------------------------------------------------
module vga_pattern_control
  import vga_pkg::*;
#(
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BOX_SIZE           = 64,
  parameter int BOX_STEP           = 2
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        Ready_Sig,
  input  logic [10:0] Column_Addr_Sig,
  input  logic [10:0] Row_Addr_Sig,
  input  logic        HSYNC_In_Sig,
  input  logic        VSYNC_In_Sig,
  output logic        HSYNC_Sig,
  output logic        VSYNC_Sig,
  output logic        Red_Sig,
  output logic        Green_Sig,
  output logic        Blue_Sig
);

  localparam logic [7:0]  LAST_FRAME = 8'(FRAMES_PER_PATTERN - 1);
  localparam logic [10:0] BOX_LEN    = 11'(BOX_SIZE);

  pattern_t   state;
  pattern_t   state_next;
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_next;
  logic       advance;

  logic       vsync_hist;
  logic       frame_event;

  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic [10:0] box_x_lo;
  logic [10:0] box_x_hi;
  logic [10:0] box_y_lo;
  logic [10:0] box_y_hi;
  logic        in_box;
  logic        box_enable;
  logic        box_restart;

  logic [2:0] pixel_colour;

  logic [2:0] rgb_p1;
  logic       hsync_p1;
  logic       vsync_p1;

  // Frame event: vsync was high last clock and is low now.
  assign frame_event = vsync_hist & ~VSYNC_In_Sig;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      vsync_hist <= 1'b1;
      state      <= BARS;
      frame_cnt  <= '0;
    end else begin
      vsync_hist <= VSYNC_In_Sig;
      state      <= state_next;
      frame_cnt  <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    advance        = 1'b0;
    if (frame_event) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt_next = '0;
        advance        = 1'b1;
        case (state)
          BARS:    state_next = CHECKER;
          CHECKER: state_next = BOX;
          BOX:     state_next = BARS;
          default: state_next = BARS;
        endcase
      end else begin
        frame_cnt_next = frame_cnt + 8'd1;
      end
    end
  end

  // The box is parked at its start position whenever another pattern is
  // showing, so entry into BOX always begins from (0,0). A frame event that
  // changes pattern must not also step the box.
  assign box_restart = (state != BOX);
  assign box_enable  = (state == BOX) && !advance;

  vga_box_mover #(
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box_mover (
    .clk         (CLK),
    .rst_n       (RST_n),
    .frame_event (frame_event),
    .enable      (box_enable),
    .restart     (box_restart),
    .box_x       (box_x),
    .box_y       (box_y)
  );

  always_comb begin
    box_x_lo = {1'b0, box_x};
    box_y_lo = {1'b0, box_y};
    box_x_hi = box_x_lo + BOX_LEN;
    box_y_hi = box_y_lo + BOX_LEN;
    in_box   = (Column_Addr_Sig >= box_x_lo) && (Column_Addr_Sig < box_x_hi) &&
               (Row_Addr_Sig    >= box_y_lo) && (Row_Addr_Sig    < box_y_hi);
  end

  always_comb begin
    pixel_colour = BLACK;
    if (Ready_Sig) begin
      case (state)
        BARS:    pixel_colour = bar_colour(Column_Addr_Sig);
        CHECKER: pixel_colour = (Column_Addr_Sig[5] ^ Row_Addr_Sig[5]) ? BLACK : WHITE;
        BOX:     pixel_colour = in_box ? RED : BLUE;
        default: pixel_colour = BLACK;
      endcase
    end
  end

  // ---- stage p1: colour and syncs registered together ----
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rgb_p1   <= BLACK;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
    end else begin
      rgb_p1   <= pixel_colour;
      hsync_p1 <= HSYNC_In_Sig;
      vsync_p1 <= VSYNC_In_Sig;
    end
  end

  assign Red_Sig   = rgb_p1[2];
  assign Green_Sig = rgb_p1[1];
  assign Blue_Sig  = rgb_p1[0];
  assign HSYNC_Sig = hsync_p1;
  assign VSYNC_Sig = vsync_p1;

endmodule
